// File: rtl/banner_char_streamer.sv
// banner_char_streamer: streams a ROM-held ASCII banner with TAB prefix and CR/LF line endings over valid/ready.
module banner_char_streamer #(
  parameter int LINE_LEN = 113,
  parameter int NOF_LINES = 43,
  parameter int PREFIX_TAB = 1,
  parameter logic [LINE_LEN*NOF_LINES*8-1:0] ROM_INIT = {LINE_LEN*NOF_LINES{8'h20}}
) (
  input  logic       iclk,
  input  logic       ireset,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_last
);
  localparam int DEPTH = LINE_LEN * NOF_LINES;
  localparam int CW = LINE_LEN > 1 ? $clog2(LINE_LEN) : 1;
  localparam int LW = NOF_LINES > 1 ? $clog2(NOF_LINES) : 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_PREFIX, S_BODY, S_CR, S_LF, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_n, w_first;
  logic [CW-1:0] r_col, w_col_n;
  logic [LW-1:0] r_line, w_line_n;
  logic [AW-1:0] w_addr;
  logic [7:0] r_rom_q, w_rom, w_beat;
  logic w_load, w_col_end, w_line_end, w_abort;
  // r_state/r_col/r_line name the beat loaded next into the output register;
  // the ROM is read at the upcoming position so its data is ready when needed.
  always_comb begin
    w_first = PREFIX_TAB != 0 ? S_PREFIX : S_BODY;
    w_col_end = r_col == CW'(LINE_LEN - 1);
    w_line_end = r_line == LW'(NOF_LINES - 1);
    w_abort = i_abort && r_state != S_IDLE;
    w_load = (r_state inside {S_PREFIX, S_BODY, S_CR, S_LF}) && (!o_valid || i_ready);
    w_beat = r_state == S_PREFIX ? 8'h09 : r_state == S_BODY ? r_rom_q : r_state == S_CR ? 8'h0D : 8'h0A;
    w_state_n = r_state;
    w_col_n = r_col;
    w_line_n = r_line;
    if (w_abort) begin
      w_state_n = S_IDLE;
      w_col_n = '0;
      w_line_n = '0;
    end else begin
      case (r_state)
        S_IDLE:   w_state_n = i_start && !i_abort ? S_START : S_IDLE;
        S_START:  w_state_n = w_first;
        S_PREFIX: w_state_n = w_load ? S_BODY : S_PREFIX;
        S_BODY: if (w_load) begin
          w_col_n = w_col_end ? '0 : r_col + 1'b1;
          w_state_n = w_col_end ? S_CR : S_BODY;
        end
        S_CR:     w_state_n = w_load ? S_LF : S_CR;
        S_LF: if (w_load) begin
          w_line_n = w_line_end ? '0 : r_line + 1'b1;
          w_state_n = w_line_end ? S_DRAIN : w_first;
        end
        S_DRAIN:  w_state_n = o_valid && i_ready ? S_DONE : S_DRAIN;
        default:  w_state_n = S_IDLE;
      endcase
    end
    w_addr = AW'(int'(w_line_n) * LINE_LEN + int'(w_col_n));
    // ROM byte 0 sits in the most significant position so a string literal reads naturally
    w_rom = ROM_INIT[(DEPTH - 1 - int'(w_addr)) * 8 +: 8];
  end
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= S_IDLE;
      r_col <= '0;
      r_line <= '0;
      r_rom_q <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_last <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_col <= w_col_n;
      r_line <= w_line_n;
      r_rom_q <= w_rom;
      if (w_abort) begin
        o_valid <= 1'b0;
        o_last <= 1'b0;
      end else if (w_load) begin
        o_valid <= 1'b1;
        o_data <= w_beat;
        o_last <= r_state == S_LF && w_line_end;
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_last <= 1'b0;
      end
    end
  end
  assign o_busy = r_state != S_IDLE;
endmodule
